// File: rtl/bcd_rtc_core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : bcd_rtc_core_pkg                                           |
// | Description : Shared definitions for the BCD time-of-day core: adjust    |
// |               field codes, BCD limits and BCD step / 12 h helpers.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package bcd_rtc_core_pkg;

  // Adjust field selector; the encoding is visible on o_adjust_cnt.
  typedef enum logic [1:0] {
    FIELD_RUN  = 2'd0,
    FIELD_SEC  = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_HOUR = 2'd3
  } field_e;

  localparam logic [7:0] BCD_MAX_MS   = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;
  localparam logic [7:0] BCD_NOON     = 8'h12;

  // +1 on a two-digit BCD value, wrapping max -> 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)              r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // -1 on a two-digit BCD value, wrapping 00 -> max.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == 8'h00)            r = max;
    else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
    else                       r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // 24 h BCD hour to 12 h BCD display: 00 -> 12, 13..23 -> 01..11.
  function automatic logic [7:0] bcd24_to_12(input logic [7:0] h);
    logic [4:0] bin;
    logic [7:0] r;
    bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (bin == 5'd0)       bin = 5'd12;
    else if (bin > 5'd12)  bin = bin - 5'd12;
    if (bin >= 5'd10)      r = {4'd1, 4'(bin - 5'd10)};
    else                   r = {4'd0, bin[3:0]};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_fall_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : btn_fall_sync                                              |
// | Description : Multi-flop synchroniser for an asynchronous button pin,    |
// |               followed by a one-cycle falling-edge pulse.                |
// | Revision    : 1.0  initial release                                       |
// | Ports       : i_clk      system clock                                    |
// |               i_reset_n  asynchronous active-low reset                   |
// |               i_btn      raw button pin (idle high)                      |
// |               o_fall     one-cycle pulse per synchronised falling edge   |
// +--------------------------------------------------------------------------+
module btn_fall_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_btn};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  // Everything idles high so a button already low at reset release
  // still produces exactly one edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  // Combinational from flops so the field changes on the edge after the
  // synchroniser output drops (3rd edge with two stages).
  assign o_fall = edge_q & ~sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/bcd_rtc_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bcd_rtc_core                                               |
// | Description : BCD time-of-day core with tick prescaler, 12/24 h display, |
// |               inc/dec adjust, button synchronisers and HH:MM alarm.      |
// | Revision    : 1.0  initial release                                       |
// | Ports       : i_clk, i_reset_n          clock, async active-low reset    |
// |               i_adjust/increment/decrement  raw buttons, act on fall    |
// |               i_mode_12h                1 = 12 h display              |
// |               i_alarm_en/hour/minut     alarm enable and HH:MM (24 h)  |
// |               o_hour/minut/second_h/_l  displayed time, BCD            |
// |               o_pm, o_adjust_cnt        afternoon flag, adjust field   |
// |               o_tick, o_alarm           one-cycle status pulses        |
// +--------------------------------------------------------------------------+
module bcd_rtc_core #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_adjust,
  input  logic       i_increment,
  input  logic       i_decrement,
  input  logic       i_mode_12h,
  input  logic       i_alarm_en,
  input  logic [7:0] i_alarm_hour,
  input  logic [7:0] i_alarm_minut,
  output logic [3:0] o_hour_h,
  output logic [3:0] o_hour_l,
  output logic [3:0] o_minut_h,
  output logic [3:0] o_minut_l,
  output logic [3:0] o_second_h,
  output logic [3:0] o_second_l,
  output logic       o_pm,
  output logic [1:0] o_adjust_cnt,
  output logic       o_tick,
  output logic       o_alarm
);
  import bcd_rtc_core_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          adj_fall, inc_fall, dec_fall;
  logic          inc_only, dec_only, tick;
  logic          run_en, sec_sel, min_sel, hour_sel;
  field_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic          alarm_pend_q, alarm_pend_d, alarm_q, alarm_d;
  logic [7:0]    hour_disp;

  btn_fall_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adj (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_btn(i_adjust),    .o_fall(adj_fall));
  btn_fall_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inc (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_btn(i_increment), .o_fall(inc_fall));
  btn_fall_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dec (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_btn(i_decrement), .o_fall(dec_fall));

  // Simultaneous inc and dec cancel out.
  assign inc_only = inc_fall & ~dec_fall;
  assign dec_only = dec_fall & ~inc_fall;
  assign tick     = (presc_q == PRESC_LAST);

  // Adjust FSM: next-state process.
  always_comb begin
    state_d = state_q;
    if (adj_fall) begin
      case (state_q)
        FIELD_RUN:  state_d = FIELD_SEC;
        FIELD_SEC:  state_d = FIELD_MIN;
        FIELD_MIN:  state_d = FIELD_HOUR;
        FIELD_HOUR: state_d = FIELD_RUN;
        default:    state_d = FIELD_RUN;
      endcase
    end
  end

  // Adjust FSM: output decode of the current (old) field, so an inc/dec
  // arriving with an adjust edge still lands on the field being left.
  always_comb begin
    run_en   = 1'b0;
    sec_sel  = 1'b0;
    min_sel  = 1'b0;
    hour_sel = 1'b0;
    case (state_q)
      FIELD_RUN:  run_en   = 1'b1;
      FIELD_SEC:  sec_sel  = 1'b1;
      FIELD_MIN:  min_sel  = 1'b1;
      FIELD_HOUR: hour_sel = 1'b1;
      default:    run_en   = 1'b1;
    endcase
  end

  // Prescaler, digit chain and alarm.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;

    if (run_en && tick) begin
      sec_d = bcd_inc(sec_q, BCD_MAX_MS);
      if (sec_q == BCD_MAX_MS) begin
        min_d = bcd_inc(min_q, BCD_MAX_MS);
        if (min_q == BCD_MAX_MS) hour_d = bcd_inc(hour_q, BCD_MAX_HOUR);
      end
    end

    // Clearing seconds also restarts the second so it is a full one.
    if (sec_sel && (inc_only || dec_only)) begin
      sec_d   = 8'h00;
      presc_d = '0;
    end
    if (min_sel) begin
      if (inc_only)      min_d = bcd_inc(min_q, BCD_MAX_MS);
      else if (dec_only) min_d = bcd_dec(min_q, BCD_MAX_MS);
    end
    if (hour_sel) begin
      if (inc_only)      hour_d = bcd_inc(hour_q, BCD_MAX_HOUR);
      else if (dec_only) hour_d = bcd_dec(hour_q, BCD_MAX_HOUR);
    end

    // Match on the value being loaded; the extra stage places the pulse
    // one cycle after the new time appears.
    alarm_pend_d = run_en && tick && i_alarm_en && (sec_d == 8'h00) &&
                   (min_d == i_alarm_minut) && (hour_d == i_alarm_hour);
    alarm_d      = alarm_pend_q;
  end

  // State register process.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= FIELD_RUN;
      presc_q      <= '0;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      hour_q       <= 8'h00;
      alarm_pend_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      alarm_pend_q <= alarm_pend_d;
      alarm_q      <= alarm_d;
    end
  end

  assign hour_disp    = i_mode_12h ? bcd24_to_12(hour_q) : hour_q;
  assign o_hour_h     = hour_disp[7:4];
  assign o_hour_l     = hour_disp[3:0];
  assign o_minut_h    = min_q[7:4];
  assign o_minut_l    = min_q[3:0];
  assign o_second_h   = sec_q[7:4];
  assign o_second_l   = sec_q[3:0];
  assign o_pm         = (hour_q >= BCD_NOON);
  assign o_adjust_cnt = state_q;
  assign o_tick       = tick;
  assign o_alarm      = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_rtc_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bcd_rtc_core                                            |
// | Description : Directed self-checking bench for bcd_rtc_core with a       |
// |               four-cycle tick and two-stage button synchronisers.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bcd_rtc_core;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_adjust = 1'b1, i_increment = 1'b1, i_decrement = 1'b1;
  logic       i_mode_12h = 1'b0, i_alarm_en = 1'b0;
  logic [7:0] i_alarm_hour = 8'h07, i_alarm_minut = 8'h30;
  logic [3:0] o_hour_h, o_hour_l, o_minut_h, o_minut_l, o_second_h, o_second_l;
  logic       o_pm, o_tick, o_alarm;
  logic [1:0] o_adjust_cnt;
  logic [23:0] t_now;

  int n_pass = 0;
  int n_total = 0;
  int alarm_cnt = 0;

  bcd_rtc_core #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_adjust(i_adjust), .i_increment(i_increment), .i_decrement(i_decrement),
    .i_mode_12h(i_mode_12h), .i_alarm_en(i_alarm_en),
    .i_alarm_hour(i_alarm_hour), .i_alarm_minut(i_alarm_minut),
    .o_hour_h(o_hour_h), .o_hour_l(o_hour_l),
    .o_minut_h(o_minut_h), .o_minut_l(o_minut_l),
    .o_second_h(o_second_h), .o_second_l(o_second_l),
    .o_pm(o_pm), .o_adjust_cnt(o_adjust_cnt), .o_tick(o_tick), .o_alarm(o_alarm)
  );

  always #5 i_clk = ~i_clk;
  assign t_now = {o_hour_h, o_hour_l, o_minut_h, o_minut_l, o_second_h, o_second_l};
  always @(negedge i_clk) if (o_alarm === 1'b1) alarm_cnt++;

  task automatic step(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic press_down(input logic a, input logic inc, input logic dec);
    i_adjust = ~a; i_increment = ~inc; i_decrement = ~dec;
    step(3);
  endtask

  task automatic release_btns();
    i_adjust = 1'b1; i_increment = 1'b1; i_decrement = 1'b1;
    step(3);
  endtask

  task automatic press(input logic a, input logic inc, input logic dec);
    press_down(a, inc, dec);
    release_btns();
  endtask

  // Walks the adjust fields to load hh:mm:00, returns to RUN and waits until
  // the seconds reach ss, i.e. just after a tick.
  task automatic set_time(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
    int guard;
    guard = 0;
    while (o_adjust_cnt !== 2'd1 && guard < 4) begin press(1, 0, 0); guard++; end
    press(0, 1, 0);
    press(1, 0, 0);
    guard = 0;
    while ({o_minut_h, o_minut_l} !== mm && guard < 60) begin press(0, 1, 0); guard++; end
    press(1, 0, 0);
    guard = 0;
    while ({o_hour_h, o_hour_l} !== hh && guard < 24) begin press(0, 1, 0); guard++; end
    press(1, 0, 0);
    guard = 0;
    while ({o_second_h, o_second_l} !== ss && guard < 300) begin step(1); guard++; end
    n_total++;
    if (t_now !== {hh, mm, ss} || o_adjust_cnt !== 2'd0)
      $display("FAIL set_time got %h cnt %0d want %h cnt 0", t_now, o_adjust_cnt, {hh, mm, ss});
    else n_pass++;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    step(2);
    n_total++; if (t_now !== 24'h000000) $display("FAIL reset_time got %h want 000000", t_now); else n_pass++;
    n_total++; if ({o_pm, o_adjust_cnt, o_tick, o_alarm} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {o_pm, o_adjust_cnt, o_tick, o_alarm}); else n_pass++;
    i_mode_12h = 1'b1; #1;
    n_total++; if ({o_hour_h, o_hour_l} !== 8'h12) $display("FAIL reset_hour12 got %h want 12", {o_hour_h, o_hour_l}); else n_pass++;
    i_mode_12h = 1'b0;
    step(1);
    i_reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_run_rollover();
    set_time(8'h23, 8'h59, 8'h58);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_total++;
      if (o_tick !== ((k == 3) || (k == 7)))
        $display("FAIL roll_tick k=%0d got %b want %b", k, o_tick, (k == 3) || (k == 7));
      else n_pass++;
      if (k == 4) begin
        n_total++; if ({t_now, o_pm} !== {24'h235959, 1'b1})
          $display("FAIL roll_59 got %h pm %b want 235959 pm 1", t_now, o_pm); else n_pass++;
      end
    end
    n_total++; if ({t_now, o_pm} !== {24'h000000, 1'b0})
      $display("FAIL roll_00 got %h pm %b want 000000 pm 0", t_now, o_pm); else n_pass++;
  endtask

  task automatic test_adjust_min();
    int ticks;
    set_time(8'h10, 8'h00, 8'h30);
    press(1, 0, 0);
    press(1, 0, 0);
    n_total++; if ({o_adjust_cnt, t_now} !== {2'd2, 24'h100030})
      $display("FAIL min_sel got cnt %0d %h want cnt 2 100030", o_adjust_cnt, t_now); else n_pass++;
    press(0, 0, 1);
    n_total++; if (t_now !== 24'h105930) $display("FAIL min_dec got %h want 105930", t_now); else n_pass++;
    ticks = 0;
    for (int k = 0; k < 12; k++) begin step(1); if (o_tick === 1'b1) ticks++; end
    n_total++; if ({ticks, t_now} !== {32'd3, 24'h105930})
      $display("FAIL min_frozen got ticks %0d %h want ticks 3 105930", ticks, t_now); else n_pass++;
  endtask

  task automatic test_sec_clear();
    set_time(8'h10, 8'h59, 8'h30);
    press(1, 0, 0);
    n_total++; if ({o_adjust_cnt, t_now} !== {2'd1, 24'h105930})
      $display("FAIL sec_sel got cnt %0d %h want cnt 1 105930", o_adjust_cnt, t_now); else n_pass++;
    press_down(0, 1, 0);
    n_total++; if ({t_now, o_tick} !== {24'h105900, 1'b0})
      $display("FAIL sec_clear got %h tick %b want 105900 tick 0", t_now, o_tick); else n_pass++;
    i_increment = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_total++; if (o_tick !== (k == 3))
        $display("FAIL sec_tick k=%0d got %b want %b", k, o_tick, k == 3); else n_pass++;
    end
    n_total++; if (t_now !== 24'h105900) $display("FAIL sec_frozen got %h want 105900", t_now); else n_pass++;
  endtask

  task automatic test_hour_12h();
    set_time(8'h00, 8'h00, 8'h05);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    n_total++; if ({o_adjust_cnt, o_hour_h, o_hour_l} !== {2'd3, 8'h00})
      $display("FAIL hour_sel got cnt %0d hour %h want cnt 3 hour 00", o_adjust_cnt, {o_hour_h, o_hour_l}); else n_pass++;
    press(0, 0, 1);
    n_total++; if ({o_hour_h, o_hour_l, o_pm} !== {8'h23, 1'b1})
      $display("FAIL hour_dec got %h pm %b want 23 pm 1", {o_hour_h, o_hour_l}, o_pm); else n_pass++;
    i_mode_12h = 1'b1; #1;
    n_total++; if ({o_hour_h, o_hour_l, o_pm} !== {8'h11, 1'b1})
      $display("FAIL h12_23 got %h pm %b want 11 pm 1", {o_hour_h, o_hour_l}, o_pm); else n_pass++;
    press(0, 1, 0);
    n_total++; if ({o_hour_h, o_hour_l, o_pm} !== {8'h12, 1'b0})
      $display("FAIL h12_00 got %h pm %b want 12 pm 0", {o_hour_h, o_hour_l}, o_pm); else n_pass++;
    press(0, 1, 0);
    n_total++; if ({o_hour_h, o_hour_l, o_pm} !== {8'h01, 1'b0})
      $display("FAIL h12_01 got %h pm %b want 01 pm 0", {o_hour_h, o_hour_l}, o_pm); else n_pass++;
    i_mode_12h = 1'b0;
  endtask

  task automatic test_alarm();
    i_alarm_en = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    alarm_cnt = 0;
    step(4);
    n_total++; if ({t_now, o_alarm} !== {24'h073000, 1'b0})
      $display("FAIL alarm_t0 got %h alarm %b want 073000 alarm 0", t_now, o_alarm); else n_pass++;
    step(1);
    n_total++; if (o_alarm !== 1'b1) $display("FAIL alarm_t1 got %b want 1", o_alarm); else n_pass++;
    step(1);
    n_total++; if (o_alarm !== 1'b0) $display("FAIL alarm_t2 got %b want 0", o_alarm); else n_pass++;
    step(2);
    n_total++; if (alarm_cnt !== 1) $display("FAIL alarm_width got %0d want 1", alarm_cnt); else n_pass++;
  endtask

  task automatic test_alarm_disabled();
    i_alarm_en = 1'b0;
    set_time(8'h07, 8'h29, 8'h59);
    alarm_cnt = 0;
    step(8);
    n_total++; if ({t_now, alarm_cnt} !== {24'h073001, 32'd0})
      $display("FAIL alarm_off got %h pulses %0d want 073001 pulses 0", t_now, alarm_cnt); else n_pass++;
  endtask

  task automatic test_alarm_adjust();
    i_alarm_en = 1'b1;
    set_time(8'h07, 8'h29, 8'h05);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    alarm_cnt = 0;
    press(0, 1, 0);
    step(4);
    n_total++; if ({o_adjust_cnt, t_now, alarm_cnt} !== {2'd2, 24'h073000, 32'd0})
      $display("FAIL alarm_adj got cnt %0d %h pulses %0d want cnt 2 073000 pulses 0", o_adjust_cnt, t_now, alarm_cnt);
    else n_pass++;
  endtask

  task automatic test_inc_dec_same();
    press(0, 1, 1);
    n_total++; if ({o_adjust_cnt, t_now} !== {2'd2, 24'h073000})
      $display("FAIL incdec got cnt %0d %h want cnt 2 073000", o_adjust_cnt, t_now); else n_pass++;
  endtask

  task automatic test_reset_mid_adjust();
    i_reset_n = 1'b0; #2;
    n_total++; if ({t_now, o_pm, o_adjust_cnt, o_tick, o_alarm} !== {24'h000000, 5'b0})
      $display("FAIL midreset got %h flags %b want 000000 flags 00000", t_now, {o_pm, o_adjust_cnt, o_tick, o_alarm});
    else n_pass++;
    step(2);
    i_reset_n = 1'b1;
    step(2);
    n_total++; if ({o_adjust_cnt, t_now} !== {2'd0, 24'h000000})
      $display("FAIL postreset got cnt %0d %h want cnt 0 000000", o_adjust_cnt, t_now); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_run_rollover();
    test_adjust_min();
    test_sec_clear();
    test_hour_12h();
    test_alarm();
    test_alarm_disabled();
    test_alarm_adjust();
    test_inc_dec_same();
    test_reset_mid_adjust();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
